// File: rtl/clk_en_gen.sv
// clk_en_gen: symbol phase counter producing half-rate, sample and symbol clock enables
module clk_en_gen #(
  parameter int CNT_W     = 4,
  parameter int SAM_RATIO = 4,
  parameter int SYM_RATIO = 16
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             run,
  input  logic             sync,
  output logic [CNT_W-1:0] clk_phase,
  output logic             half_clk_ena,
  output logic             sam_clk_ena,
  output logic             sym_clk_ena,
  output logic [CNT_W-1:0] sam_idx,
  output logic [15:0]      sym_cnt,
  output logic             locked
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SYM_RATIO - 1);
  if (SAM_RATIO < 2 || SAM_RATIO % 2 != 0 || SYM_RATIO < SAM_RATIO ||
      SYM_RATIO % SAM_RATIO != 0 || SYM_RATIO > (1 << CNT_W)) begin : g_bad_params
    $error("clk_en_gen: illegal CNT_W/SAM_RATIO/SYM_RATIO combination");
  end
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             locked_q, locked_d;
  logic             en;
  logic [31:0]      ph_w;
  assign clk_phase = phase_q;
  assign sym_cnt   = cnt_q;
  assign locked    = locked_q;
  // enables decode straight from the registered phase; masked by reset so they read 0 while it is held
  always_comb begin
    en           = run & ~sync & ~reset;
    ph_w         = 32'(phase_q);
    half_clk_ena = en & phase_q[0];
    sam_clk_ena  = en & (ph_w % SAM_RATIO == SAM_RATIO - 1);
    sym_clk_ena  = en & (phase_q == LAST);
    sam_idx      = CNT_W'(ph_w / SAM_RATIO);
  end
  // next state: sync realigns everything, otherwise run advances the phase and counts symbols
  always_comb begin
    phase_d  = sync ? '0 : run ? (phase_q == LAST ? '0 : phase_q + 1'b1) : phase_q;
    cnt_d    = sync ? '0 : cnt_q + 16'(sym_clk_ena);
    locked_d = ~sync & (locked_q | sym_clk_ena);
  end
  // state registers with asynchronous clear
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      phase_q  <= '0;
      cnt_q    <= '0;
      locked_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      locked_q <= locked_d;
    end
  end
endmodule

// File: tb/tb_clk_en_gen.sv
// tb_clk_en_gen: directed vector bench for clk_en_gen (default and 5/6/24 configurations)
module tb_clk_en_gen;
  logic sys_clk = 1'b0, reset = 1'b1, run = 1'b0, sync = 1'b0;
  logic [3:0]  a_ph, a_idx;
  logic        a_h, a_sa, a_sy, a_lk;
  logic [15:0] a_cnt;
  logic [4:0]  b_ph, b_idx;
  logic        b_h, b_sa, b_sy, b_lk;
  logic [15:0] b_cnt;
  int checks = 0, errors = 0;
  typedef struct { int run, sync, ph, h, sa, sy, cnt, lk; } vec_t;
  vec_t tbl[24];

  always #5 sys_clk = ~sys_clk;

  clk_en_gen dut_a (
    .sys_clk(sys_clk), .reset(reset), .run(run), .sync(sync),
    .clk_phase(a_ph), .half_clk_ena(a_h), .sam_clk_ena(a_sa), .sym_clk_ena(a_sy),
    .sam_idx(a_idx), .sym_cnt(a_cnt), .locked(a_lk)
  );

  clk_en_gen #(.CNT_W(5), .SAM_RATIO(6), .SYM_RATIO(24)) dut_b (
    .sys_clk(sys_clk), .reset(reset), .run(run), .sync(sync),
    .clk_phase(b_ph), .half_clk_ena(b_h), .sam_clk_ena(b_sa), .sym_clk_ena(b_sy),
    .sam_idx(b_idx), .sym_cnt(b_cnt), .locked(b_lk)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic chk_a(input string n, input int ph, h, sa, sy, cnt, lk);
    chk({n, " phase"}, 32'(a_ph), ph);
    chk({n, " half"}, 32'(a_h), h);
    chk({n, " sam"}, 32'(a_sa), sa);
    chk({n, " sym"}, 32'(a_sy), sy);
    chk({n, " sam_idx"}, 32'(a_idx), ph / 4);
    chk({n, " sym_cnt"}, 32'(a_cnt), cnt);
    chk({n, " locked"}, 32'(a_lk), lk);
  endtask

  task automatic chk_b(input string n, input int ph, h, sa, sy, cnt, lk);
    chk({n, " b_phase"}, 32'(b_ph), ph);
    chk({n, " b_half"}, 32'(b_h), h);
    chk({n, " b_sam"}, 32'(b_sa), sa);
    chk({n, " b_sym"}, 32'(b_sy), sy);
    chk({n, " b_sam_idx"}, 32'(b_idx), ph / 6);
    chk({n, " b_sym_cnt"}, 32'(b_cnt), cnt);
    chk({n, " b_locked"}, 32'(b_lk), lk);
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0,  0, 0, 0, 2, 1};
    tbl[1]  = '{1, 0, 1,  1, 0, 0, 2, 1};
    tbl[2]  = '{1, 0, 2,  0, 0, 0, 2, 1};
    tbl[3]  = '{1, 0, 3,  1, 1, 0, 2, 1};
    tbl[4]  = '{1, 0, 4,  0, 0, 0, 2, 1};
    tbl[5]  = '{1, 0, 5,  1, 0, 0, 2, 1};
    tbl[6]  = '{0, 0, 6,  0, 0, 0, 2, 1};
    tbl[7]  = '{0, 0, 6,  0, 0, 0, 2, 1};
    tbl[8]  = '{0, 0, 6,  0, 0, 0, 2, 1};
    tbl[9]  = '{0, 0, 6,  0, 0, 0, 2, 1};
    tbl[10] = '{0, 0, 6,  0, 0, 0, 2, 1};
    tbl[11] = '{1, 0, 6,  0, 0, 0, 2, 1};
    tbl[12] = '{1, 0, 7,  1, 1, 0, 2, 1};
    tbl[13] = '{1, 0, 8,  0, 0, 0, 2, 1};
    tbl[14] = '{1, 0, 9,  1, 0, 0, 2, 1};
    tbl[15] = '{1, 0, 10, 0, 0, 0, 2, 1};
    tbl[16] = '{1, 0, 11, 1, 1, 0, 2, 1};
    tbl[17] = '{1, 0, 12, 0, 0, 0, 2, 1};
    tbl[18] = '{1, 0, 13, 1, 0, 0, 2, 1};
    tbl[19] = '{1, 0, 14, 0, 0, 0, 2, 1};
    tbl[20] = '{1, 1, 15, 0, 0, 0, 2, 1};
    tbl[21] = '{1, 0, 0,  0, 0, 0, 0, 0};
    tbl[22] = '{0, 1, 1,  0, 0, 0, 0, 0};
    tbl[23] = '{1, 0, 0,  0, 0, 0, 0, 0};
    run = 1'b1;
    #3;
    chk_a("reset", 0, 0, 0, 0, 0, 0);
    chk_b("reset", 0, 0, 0, 0, 0, 0);
    @(negedge sys_clk);
    reset = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      chk_a($sformatf("run32[%0d]", i), i % 16, i % 2, int'(i % 4 == 3), int'(i % 16 == 15), i / 16, int'(i >= 16));
      chk_b($sformatf("run32[%0d]", i), i % 24, i % 2, int'((i % 24) % 6 == 5), int'(i % 24 == 23), i / 24, int'(i >= 24));
      @(negedge sys_clk);
    end
    for (int r = 0; r < 24; r++) begin
      run  = tbl[r].run[0];
      sync = tbl[r].sync[0];
      #1;
      chk_a($sformatf("vec%0d", r), tbl[r].ph, tbl[r].h, tbl[r].sa, tbl[r].sy, tbl[r].cnt, tbl[r].lk);
      @(negedge sys_clk);
    end
    run  = 1'b1;
    sync = 1'b0;
    for (int k = 1; k < 16; k++) begin
      #1;
      chk_a($sformatf("relock%0d", k), k, k % 2, int'(k % 4 == 3), int'(k == 15), 0, 0);
      @(negedge sys_clk);
    end
    #1;
    chk_a("relocked", 0, 0, 0, 0, 1, 1);
    repeat (9) @(negedge sys_clk);
    #1;
    chk_a("pre_async", 9, 1, 0, 0, 1, 1);
    #1 reset = 1'b1;
    #1;
    chk_a("async_rst", 0, 0, 0, 0, 0, 0);
    chk_b("async_rst", 0, 0, 0, 0, 0, 0);
    @(negedge sys_clk);
    run   = 1'b0;
    reset = 1'b0;
    #1;
    chk_a("post_rst0", 0, 0, 0, 0, 0, 0);
    @(negedge sys_clk);
    #1;
    chk_a("post_rst1", 0, 0, 0, 0, 0, 0);
    @(negedge sys_clk);
    run = 1'b1;
    #1;
    chk_a("restart0", 0, 0, 0, 0, 0, 0);
    @(negedge sys_clk);
    #1;
    chk_a("restart1", 1, 1, 0, 0, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clk_en_gen.md
CLK_EN_GEN -- requirements
Module: clk_en_gen

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, meaning the width of the phase counter.
REQ-002 The block SHALL have parameter SAM_RATIO, default 4, meaning the number of sys_clk cycles per sample.
REQ-003 The block SHALL have parameter SYM_RATIO, default 16, meaning the number of sys_clk cycles per symbol.
REQ-004 The block SHALL have port sys_clk  input  1  the single system clock; all logic SHALL be clocked on its rising edge.
REQ-005 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 The block SHALL have port run  input  1  count enable; when low, the phase SHALL hold.
REQ-007 The block SHALL have port sync  input  1  synchronous phase realign request.
REQ-008 The block SHALL have port clk_phase  output  CNT_W  current phase, in the range 0..SYM_RATIO-1.
REQ-009 The block SHALL have port half_clk_ena  output  1  enable asserted once every 2 cycles.
REQ-010 The block SHALL have port sam_clk_ena  output  1  enable asserted once per sample.
REQ-011 The block SHALL have port sym_clk_ena  output  1  enable asserted once per symbol.
REQ-012 The block SHALL have port sam_idx  output  CNT_W  sample index within the symbol.
REQ-013 The block SHALL have port sym_cnt  output  16  free-running symbol counter.
REQ-014 The block SHALL have port locked  output  1  high once at least one complete symbol period has elapsed since reset or sync.

Function
REQ-015 The parameters SHALL satisfy: SAM_RATIO >= 2, SAM_RATIO even, SYM_RATIO a multiple of SAM_RATIO, and SYM_RATIO <= 2^CNT_W; any violation SHALL produce an elaboration-time error.
REQ-016 Phase update: with run=1 and sync=0, clk_phase SHALL advance by 1 per cycle and wrap from SYM_RATIO-1 to 0.
REQ-017 With run=0 and sync=0, clk_phase, sym_cnt and locked SHALL hold their values.
REQ-018 sync=1 SHALL take priority over run: at the next edge, clk_phase SHALL become 0, sym_cnt SHALL become 0 and locked SHALL become 0, regardless of run.
REQ-019 half_clk_ena SHALL equal run AND NOT sync AND (clk_phase mod 2 == 1).
REQ-020 sam_clk_ena SHALL equal run AND NOT sync AND (clk_phase mod SAM_RATIO == SAM_RATIO-1).
REQ-021 sym_clk_ena SHALL equal run AND NOT sync AND (clk_phase == SYM_RATIO-1).
REQ-022 All enables SHALL be decoded combinationally from the registered phase in the same cycle, with zero latency from clk_phase; no enable SHALL be asserted while run=0 or sync=1.
REQ-023 sam_idx SHALL equal clk_phase / SAM_RATIO (integer division), zero-extended, in the range 0..SYM_RATIO/SAM_RATIO-1.
REQ-024 sym_cnt SHALL increment by 1 at the edge ending any cycle with sym_clk_ena=1, and SHALL wrap from 0xFFFF to 0x0000 without flagging.
REQ-025 locked SHALL set at the edge ending the first cycle with sym_clk_ena=1 after reset or sync, and SHALL remain set until the next reset or sync.
REQ-026 run toggling mid-symbol SHALL NOT alter the phase alignment: the phase resumes from its held value.
REQ-027 Within one symbol period with run continuously high, exactly SYM_RATIO/2 half_clk_ena pulses, SYM_RATIO/SAM_RATIO sam_clk_ena pulses and 1 sym_clk_ena pulse SHALL occur, and sym_clk_ena SHALL coincide with a sam_clk_ena and a half_clk_ena pulse.

Reset
REQ-028 While reset=1, clk_phase SHALL be 0, sym_cnt 0 and locked 0, asynchronously and without waiting for a clock edge; all enables SHALL be 0 and sam_idx SHALL be 0.
REQ-029 Assertion of reset mid-symbol SHALL immediately clear all state; after release, counting SHALL restart from phase 0 on the first edge at which run=1.

Verification
REQ-030 Defaults, reset released, run=1 held for 32 cycles -> clk_phase 0..15,0..15; sam_clk_ena at phases 3,7,11,15; sym_clk_ena at phase 15 only; sym_cnt=2; locked rises after the first phase 15.
REQ-031 Defaults, run=1 to phase 6, run=0 for 5 cycles, then run=1 -> clk_phase holds at 6 with all enables 0 while run=0, then resumes at 7.
REQ-032 Defaults, sync=1 pulsed for 1 cycle while clk_phase=15 -> sym_clk_ena=0 in that cycle, then clk_phase=0, sym_cnt=0, locked=0; locked sets again 16 cycles later.
REQ-033 Defaults, sym_cnt preloaded to 0xFFFF by running 65535 symbols, then one more symbol -> sym_cnt=0x0000 and locked stays 1.
REQ-034 CNT_W=5, SAM_RATIO=6, SYM_RATIO=24, run=1 -> sam_clk_ena at phases 5,11,17,23; sam_idx steps 0..3; sym_clk_ena at phase 23.
REQ-035 reset asserted asynchronously between edges while clk_phase=9 -> outputs are 0 immediately, before the next edge.
